// File: rtl/fft_pkg.sv
// Shared constants for the FFT capture and spectrum display paths:
// default frame length, one-hot state encoding and {re,im} packing widths.
package fft_pkg;

  localparam int FRAME_LEN_DEF = 256;

  localparam int RE_W   = 16;
  localparam int IM_W   = 16;
  localparam int CPLX_W = RE_W + IM_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_FILL = 3'b010,
    ST_SEND = 3'b100
  } state_t;

endpackage

// File: rtl/fft_src_buf.sv
// Simple dual-port frame buffer: one write port, one read port with a
// registered read that holds its value while the read enable is low.
module fft_src_buf #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_source.sv
// Captures FRAME_LEN ADC samples on request and streams them to the FFT core.
// Optional Bartlett windowing of stored samples: define FFT_SRC_WINDOW_EN.
module fft_frame_source
  import fft_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ADC_W     = 8,
  parameter int GAIN_SHL  = 4
) (
  input  logic              fft_clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic              frame_req,
  output logic [CPLX_W-1:0] fft_data_out,
  output logic              fft_data_valid,
  input  logic              fft_data_ready,
  output logic              fft_data_last,
  output logic              busy
);

  localparam int AW    = $clog2(FRAME_LEN);
  localparam int CEN_W = ADC_W + 1;
  localparam int SHL_W = CEN_W + GAIN_SHL;
  localparam int XW    = SHL_W + RE_W;
  localparam logic [AW-1:0]        LAST_IDX = AW'(FRAME_LEN - 1);
  localparam logic signed [XW-1:0] SAT_MAX  = XW'(2**(RE_W-1) - 1);
  localparam logic signed [XW-1:0] SAT_MIN  = XW'(-(2**(RE_W-1)));

  function automatic logic signed [RE_W-1:0] sat_re(input logic signed [SHL_W-1:0] v);
    logic signed [XW-1:0] vx;
    vx = XW'(v);
    if (vx > SAT_MAX)      sat_re = SAT_MAX[RE_W-1:0];
    else if (vx < SAT_MIN) sat_re = SAT_MIN[RE_W-1:0];
    else                   sat_re = vx[RE_W-1:0];
  endfunction

`ifdef FFT_SRC_WINDOW_EN
  localparam int PW = RE_W + AW + 2;

  // Weight is 2n rising then 2(N-1-n) falling; for the upper half N-1-n is ~n.
  function automatic logic signed [RE_W-1:0] window_apply(input logic signed [RE_W-1:0] re,
                                                          input logic [AW-1:0] n);
    logic [AW:0]          w;
    logic signed [PW-1:0] prod;
    w    = n[AW-1] ? {~n, 1'b0} : {n, 1'b0};
    prod = PW'(re) * PW'($signed({1'b0, w}));
    window_apply = RE_W'(prod >>> AW);
  endfunction
`endif

  state_t state, state_next;

  logic [AW-1:0]          wr_idx;
  logic [AW-1:0]          rd_idx;
  logic                   fill_fire;
  logic                   rd_adv;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [RE_W-1:0]        wr_data;
  logic [RE_W-1:0]        rd_re;
  logic                   rd_vld_p1;
  logic                   rd_last_p1;
  logic signed [CEN_W-1:0] cen_p0;
  logic signed [SHL_W-1:0] shl_p0;
  logic signed [RE_W-1:0]  sample_p0;

  // ---- stage p0: centre, gain, saturate ----
  assign cen_p0    = $signed({1'b0, adc_data}) - $signed(CEN_W'(2**(ADC_W-1)));
  assign shl_p0    = SHL_W'(cen_p0) <<< GAIN_SHL;
  assign sample_p0 = sat_re(shl_p0);

  assign fill_fire = (state == ST_FILL) && adc_valid;

`ifdef FFT_SRC_WINDOW_EN
  // ---- stage p1: window multiply, buffer write ----
  logic                   vld_p1;
  logic signed [RE_W-1:0] re_p1;
  logic [AW-1:0]          idx_p1;

  always_ff @(posedge fft_clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= fill_fire;
  end

  always_ff @(posedge fft_clk) begin
    re_p1  <= sample_p0;
    idx_p1 <= wr_idx;
  end

  assign wr_en   = vld_p1;
  assign wr_addr = idx_p1;
  assign wr_data = window_apply(re_p1, idx_p1);
`else
  assign wr_en   = fill_fire;
  assign wr_addr = wr_idx;
  assign wr_data = sample_p0;
`endif

  fft_src_buf #(
    .DEPTH  (FRAME_LEN),
    .DATA_W (RE_W)
  ) u_buf (
    .clk   (fft_clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_adv),
    .raddr (rd_idx),
    .rdata (rd_re)
  );

  always_ff @(posedge fft_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Read only when the output slot is free or being drained; once the last
  // index sits in the output stage no further reads are issued.
  always_comb begin
    state_next = state;
    rd_adv     = 1'b0;
    case (state)
      ST_IDLE: if (frame_req) state_next = ST_FILL;
      ST_FILL: if (fill_fire && (wr_idx == LAST_IDX)) state_next = ST_SEND;
      ST_SEND: begin
        rd_adv = (!rd_vld_p1 || fft_data_ready) && !(rd_vld_p1 && rd_last_p1);
        if (rd_vld_p1 && rd_last_p1 && fft_data_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge fft_clk or posedge rst) begin
    if (rst) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      if (fill_fire) wr_idx <= wr_idx + 1'b1;
      if (rd_adv) begin
        rd_idx     <= rd_idx + 1'b1;
        rd_vld_p1  <= 1'b1;
        rd_last_p1 <= (rd_idx == LAST_IDX);
      end else if (rd_vld_p1 && fft_data_ready) begin
        rd_vld_p1  <= 1'b0;
        rd_last_p1 <= 1'b0;
      end
    end
  end

  // ---- stage p1: stream output ----
  assign fft_data_valid = rd_vld_p1;
  assign fft_data_last  = rd_last_p1;
  assign fft_data_out   = rd_vld_p1 ? {rd_re, {IM_W{1'b0}}} : '0;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_fft_frame_source.sv
// Randomised bench for fft_frame_source with a frame-level reference model.
module tb_fft_frame_source;

  localparam int N     = 256;
  localparam int GAIN  = 4;
`ifdef FFT_SRC_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        frame_req = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] dout;
  logic        dvalid, dlast, busy;

  logic [7:0]  s_adc = '0;
  logic        s_vld = 1'b0;
  logic        s_req = 1'b0;
  logic        s_ready = 1'b1;
  logic [31:0] s_out;
  logic        s_valid, s_last, s_busy;

  always #5 clk = ~clk;

  fft_frame_source #(.FRAME_LEN(N), .ADC_W(8), .GAIN_SHL(GAIN)) dut (
    .fft_clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .frame_req(frame_req), .fft_data_out(dout), .fft_data_valid(dvalid),
    .fft_data_ready(ready), .fft_data_last(dlast), .busy(busy));

  fft_frame_source #(.FRAME_LEN(4), .ADC_W(8), .GAIN_SHL(9)) u_sat (
    .fft_clk(clk), .rst(rst), .adc_data(s_adc), .adc_valid(s_vld),
    .frame_req(s_req), .fft_data_out(s_out), .fft_data_valid(s_valid),
    .fft_data_ready(s_ready), .fft_data_last(s_last), .busy(s_busy));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected stored re for ADC code adc at frame index n.
  function automatic logic [15:0] exp_re(input int adc, input int n, input int gshl, input int flen);
    int     v, w;
    longint p;
    v = (adc - 128) * (1 << gshl);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    w = (n < flen / 2) ? 2 * n : 2 * (flen - 1 - n);
    p = longint'(v) * w;
    if (WIN) v = int'(p >>> $clog2(flen));
    return 16'(v);
  endfunction

  // Reference model: 0 idle, 1 filling, 2 sending
  int          mmode = 0;
  logic [15:0] frame_q[$];
  logic [15:0] exp_q[$];
  int          sent = 0;
  int          wait_cnt = 0;
  int          frames_done = 0;
  bit          cont_ready = 1'b0;
  logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mmode = 0;
      frame_q.delete();
      exp_q.delete();
      sent = 0;
      prev_vld = 1'b0;
    end else begin
      prev_vld  = dvalid;
      prev_rdy  = ready;
      prev_data = dout;
      prev_last = dlast;
      case (mmode)
        0: if (frame_req) begin mmode = 1; frame_q.delete(); end
        1: if (adc_valid) begin
          frame_q.push_back(exp_re(int'(adc_data), frame_q.size(), GAIN, N));
          if (frame_q.size() == N) begin
            mmode = 2; exp_q = frame_q; sent = 0; wait_cnt = 0;
          end
        end
        default: if (dvalid && ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          sent++;
          if (sent == N) begin mmode = 0; frames_done++; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [15:0] head;
    if (rst) begin
      check("rst_valid", 32'(dvalid), 32'd0);
      check("rst_last",  32'(dlast),  32'd0);
      check("rst_busy",  32'(busy),   32'd0);
      check("rst_data",  dout,        32'd0);
    end else begin
      check("busy", 32'(busy), 32'(mmode != 0));
      if (mmode != 2) begin
        check("valid_outside_send", 32'(dvalid), 32'd0);
      end else begin
        if (prev_vld && !prev_rdy) begin
          check("stall_valid", 32'(dvalid), 32'd1);
          check("stall_data",  dout, prev_data);
          check("stall_last",  32'(dlast), 32'(prev_last));
        end
        if (dvalid) begin
          head = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
          check($sformatf("data_beat%0d", sent), dout, {head, 16'h0000});
          check($sformatf("last_beat%0d", sent), 32'(dlast), 32'(sent == N - 1));
        end else if (sent == 0) begin
          wait_cnt++;
          check("first_beat_latency", 32'(wait_cnt <= 2), 32'd1);
        end
        if (cont_ready && sent > 0) check("no_bubble", 32'(dvalid), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // data_mode: 0 ramp, 1 random, 2 constant 255. rdy_mode: 0 always, 1 random.
  task automatic run_frame(input int data_mode, input int rdy_mode, input bit gaps,
                           input bit noisy, input int abort_after);
    int n, guard;
    cont_ready = (rdy_mode == 0);
    ready = 1'b1;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    n = 0;
    while (n < N) begin
      adc_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      adc_data  = (data_mode == 0) ? 8'(n) : (data_mode == 1) ? 8'($urandom) : 8'hFF;
      frame_req = noisy && ($urandom_range(0, 15) == 0);
      tick();
      if (adc_valid) n++;
    end
    adc_valid = 1'b0;
    frame_req = 1'b0;
    guard = 0;
    while (mmode != 0 && guard < 20000) begin
      ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (noisy) begin
        frame_req = 1'b1;
        adc_valid = 1'($urandom_range(0, 1));
        adc_data  = 8'($urandom);
      end
      if (abort_after >= 0 && sent == abort_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
      guard++;
    end
    if (guard >= 20000) begin
      checks++; errors++;
      $display("FAIL frame_timeout actual=%0d cycles required=<20000", guard);
    end
    frame_req = 1'b0;
    adc_valid = 1'b0;
    ready = 1'b1;
    check("frame_drained", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  logic [31:0] sat_exp[4];

  initial begin
    int got;
`ifdef FFT_SRC_WINDOW_EN
    sat_exp = '{32'h0000_0000, 32'hC000_0000, 32'h3FFF_0000, 32'h0000_0000};
    check("pin_win_n0",   32'(exp_re(255, 0,   4, 256)), 32'h0000);
    check("pin_win_n127", 32'(exp_re(255, 127, 4, 256)), 32'h07E0);
    check("pin_win_n128", 32'(exp_re(255, 128, 4, 256)), 32'h07E0);
    check("pin_win_neg",  32'(exp_re(0,   1,   4, 256)), 32'hFFF0);
`else
    sat_exp = '{32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h8000_0000};
    check("pin_re_0",    32'(exp_re(0,   5, 4, 256)), 32'hF800);
    check("pin_re_255",  32'(exp_re(255, 9, 4, 256)), 32'h07F0);
    check("pin_re_128",  32'(exp_re(128, 3, 4, 256)), 32'h0000);
    check("pin_sat_hi",  32'(exp_re(255, 1, 9, 4)),   32'h7FFF);
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("idle_after_reset", 32'(busy), 32'd0);

    // Saturating instance: 4-sample frame, gain 9
    s_req = 1'b1;
    tick();
    s_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_vld = 1'b1;
      s_adc = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
    end
    s_vld = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (s_valid) begin
        check($sformatf("sat_beat%0d", got), s_out, sat_exp[got]);
        check($sformatf("sat_last%0d", got), 32'(s_last), 32'(got == 3));
        got++;
      end
    end
    check("sat_beat_count", 32'(got), 32'd4);
    tick();
    check("sat_idle", 32'(s_busy), 32'd0);

    run_frame(0, 0, 1'b0, 1'b0, -1);   // ramp, continuous ready
    run_frame(0, 1, 1'b0, 1'b0, -1);   // ramp, random backpressure
    run_frame(1, 1, 1'b1, 1'b1, -1);   // random data, gaps, spurious requests
    run_frame(1, 0, 1'b1, 1'b0, 100);  // reset after 100 beats

    ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      adc_valid = 1'b1;
      adc_data  = 8'($urandom);
      tick();
    end
    adc_valid = 1'b0;
    check("no_resume_after_abort", 32'(dvalid), 32'd0);

    run_frame(2, 1, 1'b1, 1'b0, -1);   // constant full-scale input
    run_frame(0, 0, 1'b0, 1'b0, -1);   // ramp again after all of the above
    check("frames_done", 32'(frames_done), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
